// File: rtl/row_ram_to_lcd.sv
// Read side of the UART row buffer: streams one completed row from the row RAM
// to the LCD SPI byte sender and tracks row/frame position.
module row_ram_to_lcd #(
    parameter int ROW_BYTES = 480,
    parameter int ROWS      = 320,
    parameter int ADDR_W    = 9
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              row_ready,
    input  logic [7:0]        out_data,
    output logic [ADDR_W-1:0] addr_out_index,
    output logic [7:0]        pix_data,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic              show_row_done,
    output logic [ADDR_W-1:0] row_idx,
    output logic              frame_done,
    output logic              busy,
    output logic              overrun
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(ROW_BYTES - 1);
    localparam logic [ADDR_W-1:0] LAST_ROW  = ADDR_W'(ROWS - 1);

    typedef enum logic [2:0] {IDLE, FETCH, LOAD, SEND, DONE} state_t;

    state_t state, state_nxt;
    logic   row_ready_q;
    logic   pending;
    logic   rdy_edge;
    logic   start;
    logic   accept;

    assign rdy_edge = row_ready & ~row_ready_q;
    assign start    = (state == IDLE) && (rdy_edge || pending);
    assign accept   = (state == SEND) && pix_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (rdy_edge || pending) state_nxt = FETCH;
            FETCH:   state_nxt = LOAD;
            LOAD:    state_nxt = SEND;
            SEND:    if (pix_ready) state_nxt = (addr_out_index == LAST_ADDR) ? DONE : FETCH;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy          = (state != IDLE);
        show_row_done = (state == DONE);
        frame_done    = (state == DONE) && (row_idx == LAST_ROW);
    end

    // Edges arriving while a row is in flight queue one deep; a second one is lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_ready_q <= 1'b0;
            pending     <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            row_ready_q <= row_ready;
            if (state == IDLE) begin
                pending <= 1'b0;
            end else if (rdy_edge) begin
                if (pending) overrun <= 1'b1;
                else         pending <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_out_index <= '0;
            pix_data       <= '0;
            pix_valid      <= 1'b0;
            row_idx        <= '0;
        end else begin
            if (start)
                addr_out_index <= '0;
            else if (accept && addr_out_index != LAST_ADDR)
                addr_out_index <= addr_out_index + 1'b1;

            if (state == LOAD) begin
                pix_data  <= out_data;
                pix_valid <= 1'b1;
            end else if (accept) begin
                pix_valid <= 1'b0;
            end

            if (state == DONE)
                row_idx <= (row_idx == LAST_ROW) ? '0 : row_idx + 1'b1;
        end
    end

endmodule

// File: tb/tb_row_ram_to_lcd.sv
// Randomized bench for row_ram_to_lcd: a transaction-level model of the row
// streamer is checked against the DUT every cycle, plus hand-computed pins.
module tb_row_ram_to_lcd;

    localparam int ROW_BYTES = 480;
    localparam int ROWS      = 6;
    localparam int ADDR_W    = 9;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              row_ready;
    logic [7:0]        out_data;
    logic [ADDR_W-1:0] addr_out_index;
    logic [7:0]        pix_data;
    logic              pix_valid;
    logic              pix_ready;
    logic              show_row_done;
    logic [ADDR_W-1:0] row_idx;
    logic              frame_done;
    logic              busy;
    logic              overrun;

    row_ram_to_lcd #(.ROW_BYTES(ROW_BYTES), .ROWS(ROWS), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n), .row_ready(row_ready), .out_data(out_data),
        .addr_out_index(addr_out_index), .pix_data(pix_data), .pix_valid(pix_valid),
        .pix_ready(pix_ready), .show_row_done(show_row_done), .row_idx(row_idx),
        .frame_done(frame_done), .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    logic [7:0] ram [512];
    always @(posedge clk) out_data <= ram[addr_out_index];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a row is a run of ROW_BYTES transfers, each needing two fetch cycles
    // before the byte is offered, then a one-cycle done slot.
    bit m_active, m_done, m_pend, m_ovr, m_rr_prev;
    int m_gap, m_k, m_row;
    int done_cnt = 0, frame_cnt = 0;
    bit rand_rdy = 0;
    logic [7:0] acc_q[$];

    always @(negedge clk) begin
        bit exp_valid;
        bit edge_seen;
        if (!rst_n) begin
            m_active = 0; m_done = 0; m_pend = 0; m_ovr = 0; m_rr_prev = 0;
            m_gap = 0; m_k = 0; m_row = 0;
        end
        exp_valid = m_active && !m_done && m_gap == 0;
        chk("busy", 32'(busy), 32'(m_active));
        chk("pix_valid", 32'(pix_valid), 32'(exp_valid));
        chk("show_row_done", 32'(show_row_done), 32'(m_done));
        chk("frame_done", 32'(frame_done), 32'(m_done && m_row == ROWS - 1));
        chk("row_idx", 32'(row_idx), 32'(m_row));
        chk("overrun", 32'(overrun), 32'(m_ovr));
        chk("addr", 32'(addr_out_index), 32'(m_k));
        if (exp_valid) chk("pix_data", 32'(pix_data), 32'(ram[m_k]));
        if (show_row_done) done_cnt++;
        if (frame_done) frame_cnt++;
        if (pix_valid && pix_ready) acc_q.push_back(pix_data);
        if (rst_n) begin
            edge_seen = row_ready && !m_rr_prev;
            if (!m_active) begin
                if (edge_seen || m_pend) begin
                    m_active = 1; m_k = 0; m_gap = 2; m_pend = 0;
                end
            end else begin
                if (edge_seen) begin
                    if (m_pend) m_ovr = 1;
                    else        m_pend = 1;
                end
                if (m_done) begin
                    m_done = 0; m_active = 0; m_row = (m_row + 1) % ROWS;
                end else if (m_gap > 0) begin
                    m_gap--;
                end else if (pix_ready) begin
                    if (m_k == ROW_BYTES - 1) m_done = 1;
                    else begin m_k++; m_gap = 2; end
                end
            end
            m_rr_prev = row_ready;
        end
    end

    task automatic tick();
        @(posedge clk); #1;
        pix_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    endtask

    task automatic pulse_rr();
        row_ready = 1'b1; tick(); row_ready = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin tick(); n++; end while ((m_active || m_pend) && n < 20000);
        if (m_active || m_pend) chk("wait_idle_timeout", 32'(n), 32'(0));
    endtask

    task automatic do_reset();
        rst_n = 1'b0; tick(); tick(); rst_n = 1'b1;
    endtask

    initial begin
        int n, d0, f0;
        rst_n = 1'b0; row_ready = 1'b0; pix_ready = 1'b1;
        for (int i = 0; i < 512; i++) ram[i] = 8'(i);
        tick(); tick();
        chk("reset_busy", 32'(busy), 32'(0));
        chk("reset_valid", 32'(pix_valid), 32'(0));
        chk("reset_row_idx", 32'(row_idx), 32'(0));
        rst_n = 1'b1; tick();

        // 1: one row at full rate, RAM holds addr&0xFF
        acc_q.delete();
        row_ready = 1'b1;
        n = 0;
        do begin tick(); row_ready = 1'b0; n++; end while (!show_row_done && n < 3000);
        // Counting the edge cycle as cycle 1, the pulse lands on cycle 3*ROW_BYTES+2.
        chk("row_time", 32'(n + 1), 32'(3 * ROW_BYTES + 2));
        tick();
        chk("bytes_row1", 32'(acc_q.size()), 32'(ROW_BYTES));
        if (acc_q.size() == ROW_BYTES) begin
            chk("byte0", 32'(acc_q[0]), 32'h00);
            chk("byte255", 32'(acc_q[255]), 32'hFF);
            chk("byte479", 32'(acc_q[479]), 32'hDF);
        end
        chk("row_idx_after1", 32'(row_idx), 32'(1));

        // 2: random RAM contents, random pix_ready stalls
        for (int i = 0; i < 512; i++) ram[i] = 8'($urandom);
        rand_rdy = 1;
        for (int r = 0; r < 2; r++) begin
            acc_q.delete();
            pulse_rr(); wait_idle();
            chk("bytes_stall_row", 32'(acc_q.size()), 32'(ROW_BYTES));
        end

        // 3: edge mid-row queues one row; a further edge overruns
        d0 = done_cnt;
        pulse_rr(); repeat (200) tick();
        pulse_rr(); tick();
        chk("overrun_after_one_pending", 32'(overrun), 32'(0));
        wait_idle();
        chk("rows_from_pending", 32'(done_cnt - d0), 32'(2));
        pulse_rr(); repeat (100) tick();
        pulse_rr(); repeat (100) tick();
        pulse_rr(); tick();
        chk("overrun_set", 32'(overrun), 32'(1));
        wait_idle();

        // 4: a full frame from row 0
        rand_rdy = 0;
        do_reset(); tick();
        chk("overrun_cleared", 32'(overrun), 32'(0));
        f0 = frame_cnt;
        for (int r = 0; r < ROWS; r++) begin
            pulse_rr(); wait_idle();
            if (r == ROWS - 2) chk("no_early_frame_done", 32'(frame_cnt - f0), 32'(0));
        end
        chk("frame_done_once", 32'(frame_cnt - f0), 32'(1));
        chk("row_idx_wrap", 32'(row_idx), 32'(0));

        // 5: reset in the middle of a row
        pulse_rr(); pulse_rr(); tick();
        n = 0;
        while (!(m_k == 100 && pix_valid) && n < 2000) begin tick(); n++; end
        chk("reached_byte100", 32'(m_k), 32'(100));
        d0 = done_cnt;
        rst_n = 1'b0; #1;
        chk("async_valid_low", 32'(pix_valid), 32'(0));
        chk("async_busy_low", 32'(busy), 32'(0));
        chk("async_row_idx", 32'(row_idx), 32'(0));
        tick(); tick(); rst_n = 1'b1;
        repeat (5) tick();
        chk("no_done_after_reset", 32'(done_cnt - d0), 32'(0));
        chk("no_pending_after_reset", 32'(busy), 32'(0));
        pulse_rr(); tick();
        chk("restart_addr0", 32'(addr_out_index), 32'(0));
        wait_idle();

        // 6: row_ready held high counts once
        d0 = done_cnt;
        row_ready = 1'b1;
        repeat (1000) tick();
        row_ready = 1'b0;
        wait_idle();
        repeat (10) tick();
        chk("held_ready_one_row", 32'(done_cnt - d0), 32'(1));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
